mem_r_serializer: RTL and testbench

MEM_R_SERIALIZER -- requirements
Module: mem_r_serializer

---
 rtl/mem_r_serializer_if.sv | 27 ++
 rtl/mem_r_serializer.sv | 86 ++++++++
 tb/tb_mem_r_serializer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_r_serializer_if.sv
// Read-request, line-fetch and R-beat signals between a burst master and the line serializer.
// The slave modport is the serializer side; the master modport drives requests, line data and rready.
interface mem_r_serializer_if;
  logic         arvalid_i;
  logic         arready_o;
  logic [31:0]  araddr_i;
  logic         line_req_o;
  logic [25:0]  line_addr_o;
  logic         line_rvalid_i;
  logic [511:0] line_rdata_i;
  logic         line_rerr_i;
  logic         rvalid_o;
  logic         rready_i;
  logic [63:0]  rdata_o;
  logic [1:0]   rresp_o;
  logic         rlast_o;

  modport slave (
    input  arvalid_i, araddr_i, line_rvalid_i, line_rdata_i, line_rerr_i, rready_i,
    output arready_o, line_req_o, line_addr_o, rvalid_o, rdata_o, rresp_o, rlast_o
  );

  modport master (
    output arvalid_i, araddr_i, line_rvalid_i, line_rdata_i, line_rerr_i, rready_i,
    input  arready_o, line_req_o, line_addr_o, rvalid_o, rdata_o, rresp_o, rlast_o
  );
endinterface

// File: rtl/mem_r_serializer.sv
// Fetches one 512-bit line per read request and returns it as 8 critical-word-first 64-bit beats.
// First beat 2+k cycles after AR (k = line latency); beats stall in place while rready_i is low.
module mem_r_serializer (
  input  logic               clk,
  input  logic               rst,
  mem_r_serializer_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [25:0]  r_line_addr;
  logic [2:0]   r_offset;
  logic [2:0]   r_cnt;
  logic         r_err;
  logic [511:0] r_buf;
  logic         r_line_req;

  logic         w_ar_hs;
  logic         w_r_hs;
  logic         w_send;
  logic [2:0]   w_wptr;
  logic         w_unused_lsb;

  assign w_unused_lsb = ^bus.araddr_i[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_line_addr <= '0;
      r_offset    <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_buf       <= '0;
      r_line_req  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_line_req <= w_ar_hs;
      if (w_ar_hs) begin
        r_line_addr <= bus.araddr_i[31:6];
        r_offset    <= bus.araddr_i[5:3];
        r_cnt       <= '0;
      end
      if (r_state == S_FETCH && bus.line_rvalid_i) begin
        r_buf <= bus.line_rdata_i;
        r_err <= bus.line_rerr_i;
      end
      if (w_r_hs) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  // Outputs are forced low while rst is high so an abort is visible in the same cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_send          = (r_state == S_SEND) && !rst;
    w_wptr          = r_offset + r_cnt;
    bus.arready_o   = (r_state == S_IDLE) && !rst;
    w_ar_hs         = bus.arvalid_i && bus.arready_o;
    w_r_hs          = w_send && bus.rready_i;
    bus.rvalid_o    = w_send;
    bus.rdata_o     = '0;
    bus.rresp_o     = 2'b00;
    bus.rlast_o     = 1'b0;
    bus.line_req_o  = r_line_req && !rst;
    bus.line_addr_o = r_line_addr;

    if (w_send) begin
      bus.rdata_o = r_buf[{w_wptr, 6'd0} +: 64];
      bus.rresp_o = r_err ? 2'b10 : 2'b00;
      bus.rlast_o = (r_cnt == 3'd7);
    end

    case (r_state)
      S_IDLE:  if (w_ar_hs) w_state_nxt = S_FETCH;
      S_FETCH: if (bus.line_rvalid_i) w_state_nxt = S_SEND;
      S_SEND:  if (w_r_hs && r_cnt == 3'd7) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_r_serializer.sv
// Directed bench: a transaction-level model predicts every beat and handshake signal each cycle,
// and hand-written literal expectations pin the model on the key scenarios.
module tb_mem_r_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mem_r_serializer_if bus();

  mem_r_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    l = '0;
    for (int w = 0; w < 8; w++) l[64*w +: 64] = base + 64'(w);
    return l;
  endfunction

  // ---------------- transaction-level model and per-cycle compare ----------------
  typedef struct {
    logic [63:0] d;
    logic [1:0]  r;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       b;
  logic        mdl_busy = 1'b0;
  logic        mdl_have = 1'b0;
  logic [2:0]  mdl_off = '0;
  logic [25:0] mdl_addr = '0;
  logic        prev_hs = 1'b0, prev_fill = 1'b0, prev_stall = 1'b0, prev_rst = 1'b1;
  logic [63:0] prev_d = '0;
  logic [1:0]  prev_r = '0;
  logic        prev_l = 1'b0;
  logic        done_burst;
  logic [63:0] log_d[0:255];
  logic [1:0]  log_r[0:255];
  logic        log_l[0:255];
  int          log_c[0:255];
  int          log_n = 0;

  initial begin
    forever begin
      @(negedge clk);
      done_burst = 1'b0;
      chk("arready", 64'(bus.arready_o), 64'(!mdl_busy && !rst));
      chk("line_req", 64'(bus.line_req_o), 64'(prev_hs && !rst));
      if (bus.line_req_o) chk("line_addr", 64'(bus.line_addr_o), 64'(mdl_addr));
      if (rst || prev_rst) begin
        chk("rvalid_in_reset", 64'(bus.rvalid_o), 64'd0);
        chk("rdata_in_reset", bus.rdata_o, 64'd0);
        chk("rlast_in_reset", 64'(bus.rlast_o), 64'd0);
        chk("rresp_in_reset", 64'(bus.rresp_o), 64'd0);
      end
      if (prev_fill && !rst) chk("first_beat_latency", 64'(bus.rvalid_o), 64'd1);
      if (prev_stall && !rst) begin
        chk("stall_rvalid", 64'(bus.rvalid_o), 64'd1);
        chk("stall_rdata", bus.rdata_o, prev_d);
        chk("stall_rresp", 64'(bus.rresp_o), 64'(prev_r));
        chk("stall_rlast", 64'(bus.rlast_o), 64'(prev_l));
      end
      if (bus.rvalid_o) chk("rvalid_owed", 64'(exp_q.size() > 0), 64'd1);
      if (bus.rvalid_o && bus.rready_i && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("beat_rdata", bus.rdata_o, b.d);
        chk("beat_rresp", 64'(bus.rresp_o), 64'(b.r));
        chk("beat_rlast", 64'(bus.rlast_o), 64'(b.l));
        log_d[log_n[7:0]] = bus.rdata_o;
        log_r[log_n[7:0]] = bus.rresp_o;
        log_l[log_n[7:0]] = bus.rlast_o;
        log_c[log_n[7:0]] = cyc;
        log_n++;
        done_burst = b.l;
      end

      prev_stall = bus.rvalid_o && !bus.rready_i && !rst;
      prev_d     = bus.rdata_o;
      prev_r     = bus.rresp_o;
      prev_l     = bus.rlast_o;
      prev_fill  = 1'b0;
      if (rst) begin
        mdl_busy = 1'b0;
        mdl_have = 1'b0;
        exp_q.delete();
        prev_hs = 1'b0;
      end else begin
        if (bus.line_rvalid_i && mdl_busy && !mdl_have) begin
          mdl_have  = 1'b1;
          prev_fill = 1'b1;
          for (int i = 0; i < 8; i++) begin
            int w;
            w = (int'(mdl_off) + i) % 8;
            b.d = bus.line_rdata_i[64*w +: 64];
            b.r = bus.line_rerr_i ? 2'b10 : 2'b00;
            b.l = (i == 7);
            exp_q.push_back(b);
          end
        end
        if (done_burst) begin
          mdl_busy = 1'b0;
          mdl_have = 1'b0;
        end
        prev_hs = bus.arvalid_i && bus.arready_o;
        if (prev_hs) begin
          mdl_busy = 1'b1;
          mdl_have = 1'b0;
          mdl_off  = bus.araddr_i[5:3];
          mdl_addr = bus.araddr_i[31:6];
        end
      end
      prev_rst = rst;
    end
  end

  // ---------------- stimulus helpers (drive at posedge+1) ----------------
  task automatic do_ar(input logic [31:0] a, input bit drop);
    bit got;
    got = 1'b0;
    bus.arvalid_i = 1'b1;
    bus.araddr_i  = a;
    for (int g = 0; g < 60 && !got; g++) begin
      @(negedge clk);
      if (bus.arready_o) got = 1'b1;
      @(posedge clk); #1;
    end
    if (!got) fail_now("ar_handshake");
    if (drop) bus.arvalid_i = 1'b0;
  endtask

  task automatic do_line(input int delay, input logic [63:0] base, input logic err);
    repeat (delay) begin @(posedge clk); #1; end
    bus.line_rvalid_i = 1'b1;
    bus.line_rdata_i  = mk_line(base);
    bus.line_rerr_i   = err;
    @(posedge clk); #1;
    bus.line_rvalid_i = 1'b0;
    bus.line_rerr_i   = 1'b0;
  endtask

  // mode 0: rready always high; mode 1: 1,0,1,0... ; stray pulses line_rvalid mid-burst
  task automatic run_beats(input int stop, input int mode, input bit stray);
    int n;
    n = 0;
    for (int g = 0; g < 80 && n < stop; g++) begin
      bus.rready_i      = (mode == 0) ? 1'b1 : (g % 2 == 0);
      bus.line_rvalid_i = stray && (g == 3);
      bus.line_rdata_i  = stray ? {512{1'b1}} : bus.line_rdata_i;
      @(negedge clk);
      if (bus.rvalid_o && bus.rready_i) n++;
      @(posedge clk); #1;
    end
    bus.line_rvalid_i = 1'b0;
    if (n < stop) fail_now("beats");
  endtask

  task automatic check_burst(input string tag, input int base_idx, input logic [63:0] dbase,
                             input int ord[8], input logic [1:0] resp);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_data"}, log_d[base_idx + i], dbase + 64'(ord[i]));
      chk({tag, "_resp"}, 64'(log_r[base_idx + i]), 64'(resp));
      chk({tag, "_last"}, 64'(log_l[base_idx + i]), 64'(i == 7));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ord[8];
    int bi;
    bus.arvalid_i     = 1'b0;
    bus.araddr_i      = '0;
    bus.line_rvalid_i = 1'b0;
    bus.line_rdata_i  = '0;
    bus.line_rerr_i   = 1'b0;
    bus.rready_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_arready", 64'(bus.arready_o), 64'd1);
    chk("reset_rvalid", 64'(bus.rvalid_o), 64'd0);
    chk("reset_line_addr", 64'(bus.line_addr_o), 64'd0);
    chk("reset_line_req", 64'(bus.line_req_o), 64'd0);
    @(posedge clk); #1;

    // aligned request, immediate line return, rready always high
    bi = log_n;
    do_ar(32'h0000_0040, 1'b1);
    do_line(0, 64'h0, 1'b0);
    run_beats(8, 0, 1'b0);
    bus.rready_i = 1'b0;
    chk("t1_line_addr", 64'(bus.line_addr_o), 64'h1);
    ord = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_burst("t1", bi, 64'h0, ord, 2'b00);
    chk("t1_span", 64'(log_c[bi + 7] - log_c[bi]), 64'd7);

    // critical word 5, slow line return, stray line_rvalid mid-burst
    bi = log_n;
    do_ar(32'h1234_5668, 1'b1);
    do_line(3, 64'hDEAD_0000_0000_0000, 1'b0);
    run_beats(8, 0, 1'b1);
    bus.rready_i = 1'b0;
    chk("t2_line_addr", 64'(bus.line_addr_o), 64'h48D159);
    ord = '{5, 6, 7, 0, 1, 2, 3, 4};
    check_burst("t2", bi, 64'hDEAD_0000_0000_0000, ord, 2'b00);
    chk("t2_last_word", log_d[bi + 7], 64'hDEAD_0000_0000_0004);

    // rready toggling: 8 handshakes over 15 cycles
    bi = log_n;
    do_ar(32'h0000_0080, 1'b1);
    do_line(1, 64'h1111_0000, 1'b0);
    run_beats(8, 1, 1'b0);
    bus.rready_i = 1'b0;
    ord = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_burst("t3", bi, 64'h1111_0000, ord, 2'b00);
    chk("t3_span", 64'(log_c[bi + 7] - log_c[bi]), 64'd14);

    // error response on every beat
    bi = log_n;
    do_ar(32'h0000_01D8, 1'b1);
    do_line(2, 64'hE000, 1'b1);
    run_beats(8, 0, 1'b0);
    bus.rready_i = 1'b0;
    ord = '{3, 4, 5, 6, 7, 0, 1, 2};
    check_burst("t4", bi, 64'hE000, ord, 2'b10);

    // reset during the third beat, stray line data after reset, then a clean offset-2 burst
    do_ar(32'h0000_0200, 1'b1);
    do_line(0, 64'h5000, 1'b0);
    run_beats(2, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rvalid_in_rst", 64'(bus.rvalid_o), 64'd0);
    chk("t5_arready_in_rst", 64'(bus.arready_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rready_i      = 1'b0;
    bus.line_rvalid_i = 1'b1;
    bus.line_rdata_i  = {512{1'b1}};
    @(negedge clk);
    chk("t5_arready_after", 64'(bus.arready_o), 64'd1);
    chk("t5_rvalid_after", 64'(bus.rvalid_o), 64'd0);
    @(posedge clk); #1;
    bus.line_rvalid_i = 1'b0;
    @(negedge clk);
    chk("t5_late_line_ignored", 64'(bus.rvalid_o), 64'd0);
    @(posedge clk); #1;
    bi = log_n;
    do_ar(32'h0000_0310, 1'b1);
    do_line(1, 64'h7700, 1'b0);
    run_beats(8, 0, 1'b0);
    bus.rready_i = 1'b0;
    ord = '{2, 3, 4, 5, 6, 7, 0, 1};
    check_burst("t5", bi, 64'h7700, ord, 2'b00);

    // arvalid held through a burst while the address changes
    do_ar(32'h0000_1000, 1'b0);
    bus.araddr_i = 32'h0000_2038;
    @(negedge clk);
    chk("t6_arready_busy", 64'(bus.arready_o), 64'd0);
    do_line(1, 64'hAA00, 1'b0);
    run_beats(8, 0, 1'b0);
    bus.rready_i = 1'b0;
    @(negedge clk);
    chk("t6_arready_after_last", 64'(bus.arready_o), 64'd1);
    @(posedge clk); #1;
    bus.arvalid_i = 1'b0;
    @(negedge clk);
    chk("t6_second_line_req", 64'(bus.line_req_o), 64'd1);
    chk("t6_second_line_addr", 64'(bus.line_addr_o), 64'h80);
    bi = log_n;
    do_line(1, 64'hBB00, 1'b0);
    run_beats(8, 0, 1'b0);
    bus.rready_i = 1'b0;
    ord = '{7, 0, 1, 2, 3, 4, 5, 6};
    check_burst("t6", bi, 64'hBB00, ord, 2'b00);

    repeat (3) @(posedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
